pdm_step_sequencer: RTL and testbench

Playback controller that sequences the 5-bit first-order PDM modulator core. It holds a small programmable table of (level, hold) steps. On start it plays the steps in order, issuing a one-cycle level write to the PDM core at each step and holding that level for a programmed number of cycles. Playback runs once or loops. It sits between the chip's configuration pins and the PDM core's level/write-enable inputs.

---
 rtl/pdm_step_sequencer.sv | 132 +++++++++++++
 tb/tb_pdm_step_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pdm_step_sequencer.sv
// Step-table playback controller feeding level writes to a 5-bit PDM modulator core.
// Define PDM_STEP_SEQ_ZERO_ON_END_EN to issue a final level-0 write after completion or abort.
module pdm_step_sequencer #(
    parameter  int DEPTH   = 8,
    parameter  int LEVEL_W = 5,
    parameter  int HOLD_W  = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [LEVEL_W-1:0] cfg_level,
    input  logic [HOLD_W-1:0]  cfg_hold,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [AW-1:0]      last_idx,
    output logic [LEVEL_W-1:0] level_out,
    output logic               level_we,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      step_idx
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;

    state_t              state, state_n;
    logic [AW-1:0]       idx, idx_n;
    logic [AW-1:0]       last_q, last_n;
    logic [HOLD_W-1:0]   cnt, cnt_n;
    logic                advance;
    logic                load_wr;
    logic                zero_wr;

    logic [LEVEL_W-1:0]  lvl_tab  [DEPTH];
    logic [HOLD_W-1:0]   hold_tab [DEPTH];

    // LOAD reads the table combinationally, so a write on the same edge is seen only next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvl_tab[i]  <= '0;
                hold_tab[i] <= '0;
            end
        end else if (cfg_we) begin
            lvl_tab[cfg_addr]  <= cfg_level;
            hold_tab[cfg_addr] <= cfg_hold;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            last_q <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            last_q <= last_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last_q;
        cnt_n   = cnt;
        advance = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    last_n  = last_idx;
                    idx_n   = '0;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_n = hold_tab[idx];
                if (hold_tab[idx] == '0) advance = 1'b1;
                else                     state_n = S_HOLD;
            end
            S_HOLD: begin
                cnt_n = cnt - 1'b1;
                if (cnt == HOLD_W'(1)) advance = 1'b1;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (advance) begin
            if (idx != last_q) begin
                idx_n   = idx + 1'b1;
                state_n = S_LOAD;
            end else if (loop_en) begin
                idx_n   = '0;
                state_n = S_LOAD;
            end else begin
                state_n = S_DONE;
            end
        end
        if (stop && state != S_IDLE) state_n = S_IDLE;
    end

    assign load_wr = (state == S_LOAD) && !stop;

`ifdef PDM_STEP_SEQ_ZERO_ON_END_EN
    assign zero_wr = stop ? (state == S_LOAD || state == S_HOLD) : (state == S_DONE);
`else
    assign zero_wr = 1'b0;
`endif

    // Outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_out <= '0;
            level_we  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
        end else begin
            level_we <= load_wr || zero_wr;
            if (load_wr)      level_out <= lvl_tab[idx];
            else if (zero_wr) level_out <= '0;
            busy     <= (state == S_LOAD || state == S_HOLD) && !stop;
            done     <= (state == S_DONE) && !stop;
            step_idx <= idx;
        end
    end

endmodule

// File: tb/tb_pdm_step_sequencer.sv
// Directed and randomized playback runs against an event-schedule model of the step table.
module tb_pdm_step_sequencer;
    localparam int DEPTH = 8, LW = 5, HW = 4, AW = 3, MAXE = 400;
`ifdef PDM_STEP_SEQ_ZERO_ON_END_EN
    localparam bit ZERO_END = 1'b1;
`else
    localparam bit ZERO_END = 1'b0;
`endif

    logic          clk = 1'b0, reset;
    logic          cfg_we, start, stop, loop_en;
    logic [AW-1:0] cfg_addr, last_idx;
    logic [LW-1:0] cfg_level;
    logic [HW-1:0] cfg_hold;
    logic [LW-1:0] level_out;
    logic          level_we, busy, done;
    logic [AW-1:0] step_idx;

    pdm_step_sequencer #(.DEPTH(DEPTH), .LEVEL_W(LW), .HOLD_W(HW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_level(cfg_level), .cfg_hold(cfg_hold), .start(start), .stop(stop),
        .loop_en(loop_en), .last_idx(last_idx), .level_out(level_out),
        .level_we(level_we), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int tl [DEPTH], th [DEPTH];
    int prev_out = 0, end_e;
    int e_we [MAXE+1], e_lvl [MAXE+1], e_done [MAXE+1], e_busy [MAXE+1];
    int e_sidx [MAXE+1], e_out [MAXE+1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_level_out"}, level_out, 0);
        chk({tag, "_level_we"}, level_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_step_idx"}, step_idx, 0);
    endtask

    task automatic wr(input int a, input int l, input int h);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_level = LW'(l); cfg_hold = HW'(h);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tl[a] = l; th[a] = h;
    endtask

    // Edge 0 is the edge that samples start; step k is written at 1 + sum of (hold+1) of prior steps.
    task automatic build(input int n, input int last, input int loop_off, input int stop_e,
                         input int wr_e, input int wr_a, input int wr_l, input int wr_h);
        int t, idx, lv, hd, dec, cur;
        bit fin;
        for (int e = 0; e <= MAXE; e++) begin
            e_we[e] = 0; e_lvl[e] = 0; e_done[e] = 0; e_busy[e] = 0; e_sidx[e] = -1;
        end
        t = 1; idx = 0; end_e = MAXE + 1; fin = 0;
        while (t <= n && !fin) begin
            lv = (wr_e >= 0 && wr_e < t && wr_a == idx) ? wr_l : tl[idx];
            hd = (wr_e >= 0 && wr_e < t && wr_a == idx) ? wr_h : th[idx];
            e_we[t] = 1; e_lvl[t] = lv; e_sidx[t] = idx;
            for (int k = t; k <= t + hd && k <= MAXE; k++) e_busy[k] = 1;
            dec = t + hd;
            t = dec + 1;
            if (idx != last) idx++;
            else if (dec < loop_off) idx = 0;
            else begin
                end_e = t; fin = 1;
                if (t <= MAXE) begin
                    e_done[t] = 1;
                    if (ZERO_END) begin e_we[t] = 1; e_lvl[t] = 0; end
                end
            end
        end
        if (stop_e >= 1) begin
            for (int e = stop_e; e <= MAXE; e++) begin
                e_we[e] = 0; e_done[e] = 0; e_busy[e] = 0; e_sidx[e] = -1;
            end
            if (ZERO_END && stop_e < end_e) begin e_we[stop_e] = 1; e_lvl[stop_e] = 0; end
        end
        cur = prev_out;
        for (int e = 0; e <= MAXE; e++) begin
            if (e_we[e] != 0) cur = e_lvl[e];
            e_out[e] = cur;
        end
    endtask

    task automatic run(input string tag, input int n, input int last, input int loop_off,
                       input int stop_e, input int wr_e, input int wr_a, input int wr_l,
                       input int wr_h, input bit noise);
        int lim;
        build(n, last, loop_off, stop_e, wr_e, wr_a, wr_l, wr_h);
        lim = (stop_e >= 1 && stop_e < end_e) ? stop_e : end_e;
        for (int e = 0; e <= n; e++) begin
            start    = (e == 0) || (noise && e <= lim && $urandom_range(0, 1) == 1);
            last_idx = (e == 0) ? AW'(last) : AW'($urandom);
            loop_en  = (e < loop_off);
            stop     = (e == stop_e);
            cfg_we   = (e == wr_e);
            cfg_addr = AW'(wr_a); cfg_level = LW'(wr_l); cfg_hold = HW'(wr_h);
            @(posedge clk); #1;
            chk({tag, "_we"}, level_we, e_we[e]);
            chk({tag, "_busy"}, busy, e_busy[e]);
            chk({tag, "_done"}, done, e_done[e]);
            chk({tag, "_level"}, level_out, e_out[e]);
            if (e_sidx[e] >= 0) chk({tag, "_idx"}, step_idx, e_sidx[e]);
        end
        start = 0; stop = 0; cfg_we = 0; loop_en = 0;
        if (wr_e >= 0 && wr_e <= n) begin tl[wr_a] = wr_l; th[wr_a] = wr_h; end
        prev_out = e_out[n];
    endtask

    initial begin
        reset = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_level = '0; cfg_hold = '0;
        start = 0; stop = 0; loop_en = 0; last_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin tl[i] = 0; th[i] = 0; end
        #1 chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // One-shot: writes at edges 1,4,5 (3,17,31), done at 7.
        wr(0, 3, 2); wr(1, 17, 0); wr(2, 31, 1);
        run("oneshot", 12, 2, 0, -1, -1, 0, 0, 0, 0);
        // Loop with period 6; loop_en drops before entry 2's decision at edge 18.
        run("loopdrop", 30, 2, 16, -1, -1, 0, 0, 0, 1);
        // Stop during entry 0's hold.
        run("stop", 12, 2, 0, 2, -1, 0, 0, 0, 0);
        // Rewrite entry 0 while looping; takes effect on the next loop pass.
        run("midwr", 30, 2, 1000, 20, 6, 0, 9, 0, 0);
        // Table now (9,0),(17,0),(31,1): entry 1 loads in the cycle of its rewrite at edge 6.
        run("collide", 30, 2, 1000, 25, 6, 1, 22, 3, 1);

        // start and stop together in IDLE.
        start = 1; stop = 1;
        @(posedge clk); #1;
        start = 0; stop = 0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("ss_we", level_we, 0);
            chk("ss_busy", busy, 0);
            chk("ss_level", level_out, prev_out);
        end

        // Random tables, last indices and loop/stop timing.
        for (int r = 0; r < 6; r++) begin
            int lst;
            for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 31), $urandom_range(0, 15));
            lst = (r == 0) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
            if (r % 2 == 0) run("rand_os", 150, lst, 0, -1, -1, 0, 0, 0, 1);
            else run("rand_lp", 300, lst, $urandom_range(1, 200), $urandom_range(1, 280),
                     $urandom_range(1, 100), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 31), $urandom_range(0, 15), 1);
        end

        // Async reset mid-hold, then a cleared table plays a single level 0.
        wr(0, 7, 5);
        start = 1; last_idx = '0;
        @(posedge clk); #1 start = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge clk) reset = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin tl[i] = 0; th[i] = 0; end
        prev_out = 0;
        run("cleared", 6, 0, 0, -1, -1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
